// File: rtl/sd_host_pkg.sv
// Shared SD host definitions: command-issue FSM encoding, default register map,
// status bit positions, error codes and the captured-command record.
package sd_host_pkg;

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StRdCmd  = 4'd1;
    localparam logic [3:0] StWtCmd  = 4'd2;
    localparam logic [3:0] StBusyQ  = 4'd3;
    localparam logic [3:0] StRdDat  = 4'd4;
    localparam logic [3:0] StWtDat  = 4'd5;
    localparam logic [3:0] StSetArg = 4'd6;
    localparam logic [3:0] StWtArg  = 4'd7;
    localparam logic [3:0] StSend   = 4'd8;
    localparam logic [3:0] StWtSend = 4'd9;
    localparam logic [3:0] StEnd    = 4'd10;

    localparam logic [11:0] DefStatIdx = 12'h024;
    localparam logic [11:0] DefArgIdx  = 12'h008;
    localparam logic [11:0] DefCmdIdx  = 12'h00E;

    localparam int unsigned DefCmdInhbBit = 0;
    localparam int unsigned DefDatInhbBit = 1;

    localparam logic [5:0]  DefAbortIdx = 6'h0C;
    localparam logic [31:0] DefAbortArg = 32'h0000_01AA;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrCmdTout = 2'b01;
    localparam logic [1:0] ErrDatTout = 2'b10;

    typedef struct packed {
        logic [5:0]  cmd_index;
        logic [31:0] argument;
        logic [1:0]  command_type;
        logic        data_pres_select;
        logic        cmd_indx_chk_enb;
        logic        cmd_crc_chk_enb;
        logic [1:0]  resp_type_select;
        logic        with_busy;
        logic        abort;
    } sd_cmd_t;

    // Command register image with the index supplied separately (abort override).
    function automatic logic [31:0] sd_cmd_word(input sd_cmd_t c, input logic [5:0] idx);
        return {16'b0, 2'b0, idx, c.command_type, c.data_pres_select,
                c.cmd_indx_chk_enb, c.cmd_crc_chk_enb, 1'b0, c.resp_type_select};
    endfunction

endpackage

// File: rtl/sd_wait_cntr.sv
// Settle timer: loaded by a one-cycle strobe, tout marks the last of WAIT_CLKS cycles.
module sd_wait_cntr #(
    parameter int unsigned WAIT_CLKS = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic strb,
    output logic tout
);

    localparam int unsigned CW = $clog2(WAIT_CLKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (strb) begin
            cnt_d = CW'(WAIT_CLKS);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tout = (cnt_q == CW'(1));

endmodule

// File: rtl/issue_sd_cmd_gen.sv
// Issues one SD command through the host-controller register port: polls the
// inhibit bits, writes Argument then Command, and reports success or timeout.
module issue_sd_cmd_gen
    import sd_host_pkg::*;
#(
    parameter int unsigned      IDX_W        = 12,
    parameter int unsigned      RD_W         = 128,
    parameter int unsigned      WAIT_CLKS    = 5,
    parameter int unsigned      MAX_POLLS    = 16,
    parameter logic [IDX_W-1:0] STAT_IDX     = IDX_W'(DefStatIdx),
    parameter logic [IDX_W-1:0] ARG_IDX      = IDX_W'(DefArgIdx),
    parameter logic [IDX_W-1:0] CMD_IDX      = IDX_W'(DefCmdIdx),
    parameter int unsigned      CMD_INHB_BIT = DefCmdInhbBit,
    parameter int unsigned      DAT_INHB_BIT = DefDatInhbBit,
    parameter logic [5:0]       ABORT_IDX    = DefAbortIdx,
    parameter logic [31:0]      ABORT_ARG    = DefAbortArg
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_sd_cmd_strb,
    input  logic [5:0]       cmd_index,
    input  logic [31:0]      argument,
    input  logic [1:0]       command_type,
    input  logic             data_pres_select,
    input  logic             cmd_indx_chk_enb,
    input  logic             cmd_crc_chk_enb,
    input  logic [1:0]       resp_type_select,
    input  logic             issue_cmd_with_busy,
    input  logic             issue_abort_cmd_flag,
    output logic [IDX_W-1:0] rd_reg_index,
    input  logic [RD_W-1:0]  rd_reg_input,
    output logic             wr_reg_strb,
    output logic [IDX_W-1:0] wr_reg_index,
    output logic [31:0]      wr_reg_output,
    output logic [2:0]       reg_attr,
    output logic             fin_a_cmd_strb,
    output logic             cmd_err,
    output logic [1:0]       err_code,
    output logic             iss_sd_cmd_proc
);

    localparam int unsigned PW = $clog2(MAX_POLLS + 1);

    logic [3:0]    state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [1:0]    err_q, err_d;
    sd_cmd_t       cmd_q, cmd_d;

    logic        wait_strb, wait_tout, poll_last, cmd_inhb, dat_inhb;
    logic [31:0] arg_word, cmd_word;
    logic        unused_rd_input;

    assign cmd_inhb        = rd_reg_input[CMD_INHB_BIT];
    assign dat_inhb        = rd_reg_input[DAT_INHB_BIT];
    assign unused_rd_input = ^rd_reg_input;
    assign poll_last       = (poll_q == PW'(MAX_POLLS));
    assign wait_strb       = state_q inside {StRdCmd, StRdDat, StSetArg, StSend};

    sd_wait_cntr #(
        .WAIT_CLKS(WAIT_CLKS)
    ) u_wait_cntr (
        .clk  (clk),
        .reset(reset),
        .strb (wait_strb),
        .tout (wait_tout)
    );

    always_comb begin
        state_d = state_q;
        poll_d  = poll_q;
        err_d   = err_q;
        cmd_d   = cmd_q;
        case (state_q)
            StIdle: begin
                if (issue_sd_cmd_strb) begin
                    cmd_d.cmd_index        = cmd_index;
                    cmd_d.argument         = argument;
                    cmd_d.command_type     = command_type;
                    cmd_d.data_pres_select = data_pres_select;
                    cmd_d.cmd_indx_chk_enb = cmd_indx_chk_enb;
                    cmd_d.cmd_crc_chk_enb  = cmd_crc_chk_enb;
                    cmd_d.resp_type_select = resp_type_select;
                    cmd_d.with_busy        = issue_cmd_with_busy;
                    cmd_d.abort            = issue_abort_cmd_flag;
                    poll_d  = '0;
                    err_d   = ErrNone;
                    state_d = StRdCmd;
                end
            end
            StRdCmd: begin
                poll_d  = poll_q + PW'(1);
                state_d = StWtCmd;
            end
            StWtCmd: begin
                if (wait_tout) begin
                    if (!cmd_inhb) begin
                        state_d = StBusyQ;
                    end else if (poll_last) begin
                        err_d   = ErrCmdTout;
                        state_d = StEnd;
                    end else begin
                        state_d = StRdCmd;
                    end
                end
            end
            StBusyQ: begin
                poll_d  = '0;
                state_d = (cmd_q.abort || !cmd_q.with_busy) ? StSetArg : StRdDat;
            end
            StRdDat: begin
                poll_d  = poll_q + PW'(1);
                state_d = StWtDat;
            end
            StWtDat: begin
                if (wait_tout) begin
                    if (!dat_inhb) begin
                        state_d = StSetArg;
                    end else if (poll_last) begin
                        err_d   = ErrDatTout;
                        state_d = StEnd;
                    end else begin
                        state_d = StRdDat;
                    end
                end
            end
            StSetArg: state_d = StWtArg;
            StWtArg:  if (wait_tout) state_d = StSend;
            StSend:   state_d = StWtSend;
            StWtSend: if (wait_tout) state_d = StEnd;
            StEnd:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            poll_q  <= '0;
            err_q   <= ErrNone;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
        end
    end

    assign arg_word = cmd_q.abort ? ABORT_ARG : cmd_q.argument;
    assign cmd_word = sd_cmd_word(cmd_q, cmd_q.abort ? ABORT_IDX : cmd_q.cmd_index);

    always_comb begin
        rd_reg_index   = '0;
        wr_reg_strb    = 1'b0;
        wr_reg_index   = '0;
        wr_reg_output  = '0;
        fin_a_cmd_strb = 1'b0;
        cmd_err        = 1'b0;
        case (state_q)
            StRdCmd, StWtCmd, StRdDat, StWtDat: rd_reg_index = STAT_IDX;
            StSetArg, StWtArg: begin
                wr_reg_strb   = (state_q == StSetArg);
                wr_reg_index  = ARG_IDX;
                wr_reg_output = arg_word;
            end
            StSend, StWtSend: begin
                wr_reg_strb   = (state_q == StSend);
                wr_reg_index  = CMD_IDX;
                wr_reg_output = cmd_word;
            end
            StEnd: begin
                fin_a_cmd_strb = (err_q == ErrNone);
                cmd_err        = (err_q != ErrNone);
            end
            default: ;
        endcase
    end

    assign reg_attr        = 3'b000;
    assign err_code        = err_q;
    assign iss_sd_cmd_proc = (state_q != StIdle);

endmodule
